alu_serial: RTL and testbench

- Multi-cycle, digit-serial integer ALU: the parametrised successor to the team's 1-bit ALU slice.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, carrying between digits.
- Adds XOR, signed flags and valid/ready handshakes on both sides.
- Sits between the operand register file and the writeback stage where area matters more than single-cycle latency.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_serial_if.sv | 24 ++
 rtl/alu_slice.sv | 21 ++
 rtl/alu_serial.sv | 74 +++++++
 tb/tb_alu_serial.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and state encodings shared by the serial ALU
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  function automatic logic is_arith(input logic [2:0] op);
    return op == OP_ADD || op == OP_SUB;
  endfunction
endpackage

// File: rtl/alu_serial_if.sv
// alu_serial_if: operand-side and result-side valid/ready bundle
interface alu_serial_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;
  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero, neg
  );
  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero, neg
  );
endinterface

// File: rtl/alu_slice.sv
// alu_slice: combinational DIGIT-bit ALU step; SUB arrives with b pre-inverted so it adds
module alu_slice import alu_pkg::*; #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] res,
  output logic             cout,
  output logic             c_msb
);
  logic [DIGIT:0] sum;
  logic           arith;
  assign sum   = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign arith = is_arith(op);
  assign res   = arith ? sum[DIGIT-1:0] : op == OP_AND ? a & b : op == OP_OR ? a | b :
                 op == OP_XOR ? a ^ b : '0;
  assign cout  = arith & sum[DIGIT];
  assign c_msb = arith & (sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1]);
endmodule

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU, WIDTH/DIGIT cycles per op, flags latched on the last digit
module alu_serial import alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic         clk,
  input logic         rst_n,
  alu_serial_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  state_e           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_r, res_nx;
  logic [2:0]       op_r;
  logic             c_r, carry_r, ovf_r, zero_r, neg_r;
  logic [DIGIT-1:0] s_res;
  logic             s_cout, s_cmsb, accept, last;
  assign bus.in_ready  = state == S_IDLE || (state == S_DONE && bus.out_ready);
  assign bus.out_valid = state == S_DONE;
  assign bus.result    = res_r;
  assign bus.carry     = carry_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;
  assign bus.neg       = neg_r;
  assign accept = bus.in_valid && bus.in_ready;
  assign last   = state == S_RUN && cnt == CW'(NDIG - 1);
  assign res_nx = (res_r >> DIGIT) | (WIDTH'(s_res) << (WIDTH - DIGIT));
  alu_slice #(.DIGIT(DIGIT)) u_slice (
    .a(a_sr[DIGIT-1:0]), .b(b_sr[DIGIT-1:0]), .cin(c_r), .op(op_r),
    .res(s_res), .cout(s_cout), .c_msb(s_cmsb)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  // next state: a DONE handoff with a same-cycle accept skips IDLE
  always_comb begin
    state_nx = accept ? S_RUN : state == S_RUN ? (last ? S_DONE : S_RUN) :
               (state == S_DONE && bus.out_ready) ? S_IDLE : state;
  end
  // operand capture, digit shifting and flag latch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      a_sr <= '0;
      b_sr <= '0;
      res_r <= '0;
      op_r <= '0;
      c_r <= 1'b0;
      carry_r <= 1'b0;
      ovf_r <= 1'b0;
      zero_r <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      a_sr <= bus.a;
      b_sr <= bus.op == OP_SUB ? ~bus.b : bus.b;
      op_r <= bus.op;
      c_r <= bus.op == OP_ADD ? bus.cin : bus.op == OP_SUB;
      cnt <= '0;
    end else if (state == S_RUN) begin
      a_sr <= a_sr >> DIGIT;
      b_sr <= b_sr >> DIGIT;
      res_r <= res_nx;
      c_r <= s_cout;
      cnt <= cnt + CW'(1);
      if (last) begin
        carry_r <= s_cout;
        ovf_r <= s_cout ^ s_cmsb;
        zero_r <= res_nx == '0;
        neg_r <= res_nx[WIDTH-1];
      end
    end
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: scoreboard bench for the digit-serial ALU at DIGIT=4, 1 and 16
module tb_alu_serial;
  import alu_pkg::*;
  typedef struct packed {logic [15:0] res; logic carry; logic ovf; logic zero; logic neg;} exp_t;
  typedef struct packed {logic [15:0] a; logic [15:0] b; logic cin; logic [2:0] op; exp_t e;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic sw_valid = 1'b0, sw_cin = 1'b0, sw_ready = 1'b0;
  logic [15:0] sw_a = '0, sw_b = '0;
  logic [2:0] sw_op = '0;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  alu_serial_if #(.WIDTH(16)) mif ();
  alu_serial_if #(.WIDTH(16)) if1 ();
  alu_serial_if #(.WIDTH(16)) if16 ();
  alu_serial #(.WIDTH(16), .DIGIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(mif));
  alu_serial #(.WIDTH(16), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  alu_serial #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  assign if1.in_valid = sw_valid;
  assign if1.a = sw_a;
  assign if1.b = sw_b;
  assign if1.cin = sw_cin;
  assign if1.op = sw_op;
  assign if1.out_ready = sw_ready;
  assign if16.in_valid = sw_valid;
  assign if16.a = sw_a;
  assign if16.b = sw_b;
  assign if16.cin = sw_cin;
  assign if16.op = sw_op;
  assign if16.out_ready = sw_ready;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic [2:0] op);
    logic [16:0] s;
    logic [15:0] bb;
    exp_t e;
    e = '0;
    bb = op == OP_SUB ? ~b : b;
    if (op == OP_ADD || op == OP_SUB) begin
      s = {1'b0, a} + {1'b0, bb} + (op == OP_SUB ? 17'd1 : {16'd0, c});
      e.res = s[15:0];
      e.carry = s[16];
      e.ovf = (a[15] == bb[15]) && (s[15] != a[15]);
    end else e.res = op == OP_AND ? a & b : op == OP_OR ? a | b : op == OP_XOR ? a ^ b : 16'h0;
    e.zero = e.res == 16'h0;
    e.neg = e.res[15];
    return e;
  endfunction

  function automatic exp_t obs();
    return {mif.result, mif.carry, mif.ovf, mif.zero, mif.neg};
  endfunction
  function automatic exp_t obs1();
    return {if1.result, if1.carry, if1.ovf, if1.zero, if1.neg};
  endfunction
  function automatic exp_t obs16();
    return {if16.result, if16.carry, if16.ovf, if16.zero, if16.neg};
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic [2:0] op,
                      input exp_t e, output int lat);
    mif.a = a;
    mif.b = b;
    mif.cin = c;
    mif.op = op;
    mif.in_valid = 1'b1;
    q.push_back(e);
    lat = 0;
    while (!mif.in_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    lat = 0;
    while (!mif.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_out();
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    mif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (mif.out_valid !== 1'b0 || obs() !== exp_t'(0)) begin
      n_bad++;
      $display("FAIL reset_state out_valid=%b res/flags=%h required 0/0", mif.out_valid, obs());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (mif.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", mif.in_ready); end
  endtask

  task automatic test_arith();
    vec_t v [7];
    exp_t e;
    int lat;
    v = '{{16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 4'b0101},
          {16'hFFFF, 16'h0000, 1'b1, OP_ADD, 16'h0000, 4'b1010},
          {16'h8000, 16'h8000, 1'b0, OP_ADD, 16'h0000, 4'b1110},
          {16'h0003, 16'h0005, 1'b0, OP_SUB, 16'hFFFE, 4'b0001},
          {16'h0005, 16'h0005, 1'b0, OP_SUB, 16'h0000, 4'b1010},
          {16'h0005, 16'h0005, 1'b1, OP_SUB, 16'h0000, 4'b1010},
          {16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 4'b1100}};
    for (int i = 0; i < 7; i++) begin
      send(v[i].a, v[i].b, v[i].cin, v[i].op, v[i].e, lat);
      e = q.pop_front();
      n_cmp++;
      if (lat !== 4) begin n_bad++; $display("FAIL arith_latency[%0d] got=%0d exp=4", i, lat); end
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL arith[%0d] got=%h exp=%h", i, obs(), e); end
      release_out();
    end
  endtask

  task automatic test_logic();
    vec_t v [6];
    exp_t e;
    int lat;
    v = '{{16'hF0F0, 16'h3C3C, 1'b1, OP_AND, 16'h3030, 4'b0000},
          {16'hF0F0, 16'h3C3C, 1'b1, OP_OR,  16'hFCFC, 4'b0001},
          {16'hF0F0, 16'h3C3C, 1'b0, OP_XOR, 16'hCCCC, 4'b0001},
          {16'hF0F0, 16'h0F0F, 1'b0, OP_AND, 16'h0000, 4'b0010},
          {16'hFFFF, 16'hFFFF, 1'b1, 3'b110, 16'h0000, 4'b0010},
          {16'h1234, 16'h5678, 1'b0, 3'b111, 16'h0000, 4'b0010}};
    for (int i = 0; i < 6; i++) begin
      send(v[i].a, v[i].b, v[i].cin, v[i].op, v[i].e, lat);
      e = q.pop_front();
      n_cmp++;
      if (lat !== 4) begin n_bad++; $display("FAIL logic_latency[%0d] got=%0d exp=4", i, lat); end
      n_cmp++;
      if (obs() !== e) begin n_bad++; $display("FAIL logic[%0d] got=%h exp=%h", i, obs(), e); end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, held;
    int lat;
    send(16'h1234, 16'h1111, 1'b0, OP_ADD, {16'h2345, 4'b0000}, lat);
    e = q.pop_front();
    held = obs();
    n_cmp++;
    if (held !== e || lat !== 4) begin n_bad++; $display("FAIL hold_first got=%h lat=%0d exp=%h lat=4", held, lat, e); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (obs() !== held || mif.in_ready !== 1'b0 || mif.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL backpressure[%0d] got=%h rdy=%b vld=%b exp=%h rdy=0 vld=1", i, obs(), mif.in_ready, mif.out_valid, held);
      end
    end
    mif.a = 16'hFFFF;
    mif.b = 16'h0001;
    mif.cin = 1'b0;
    mif.op = OP_SUB;
    mif.in_valid = 1'b1;
    mif.out_ready = 1'b1;
    q.push_back({16'hFFFE, 4'b1001});
    #1;
    n_cmp++;
    if (mif.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready got=%b exp=1", mif.in_ready); end
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    mif.out_ready = 1'b0;
    n_cmp++;
    if (mif.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_left_done got=%b exp=0", mif.out_valid); end
    lat = 0;
    while (!mif.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    e = q.pop_front();
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    n_cmp++;
    if (obs() !== e) begin n_bad++; $display("FAIL b2b_result got=%h exp=%h", obs(), e); end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic seen;
    mif.a = 16'hABCD;
    mif.b = 16'h1111;
    mif.cin = 1'b1;
    mif.op = OP_ADD;
    mif.in_valid = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mif.out_valid !== 1'b0 || obs() !== exp_t'(0)) begin
      n_bad++;
      $display("FAIL reset_mid vld=%b res/flags=%h required 0/0", mif.out_valid, obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (mif.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_in_ready got=%b exp=1", mif.in_ready); end
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen |= mif.out_valid; end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_mid_ghost got=%b exp=0", seen); end
  endtask

  task automatic test_sweep();
    exp_t e;
    int l1, l16;
    for (int i = 0; i < 24; i++) begin
      sw_a = i == 0 ? 16'h7FFF : i == 1 ? 16'h8000 : i == 2 ? 16'hFFFF : 16'($urandom);
      sw_b = i == 0 ? 16'h0001 : i == 1 ? 16'h0001 : i == 2 ? 16'h0000 : 16'($urandom);
      sw_op = i == 1 ? OP_SUB : i < 3 ? OP_ADD : ($urandom_range(0, 1) == 1 ? OP_SUB : OP_ADD);
      sw_cin = i == 2 ? 1'b1 : 1'($urandom);
      q.push_back(model(sw_a, sw_b, sw_cin, sw_op));
      sw_valid = 1'b1;
      n_cmp++;
      if (if1.in_ready !== 1'b1 || if16.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL sweep_ready[%0d] got=%b%b exp=11", i, if1.in_ready, if16.in_ready);
      end
      @(posedge clk); #1;
      sw_valid = 1'b0;
      l1 = -1;
      l16 = -1;
      for (int k = 0; k < 40; k++) begin
        if (l1 < 0 && if1.out_valid) l1 = k;
        if (l16 < 0 && if16.out_valid) l16 = k;
        if (l1 >= 0 && l16 >= 0) break;
        @(posedge clk); #1;
      end
      e = q.pop_front();
      n_cmp++;
      if (l1 !== 16 || l16 !== 1) begin n_bad++; $display("FAIL sweep_latency[%0d] got=%0d/%0d exp=16/1", i, l1, l16); end
      n_cmp++;
      if (obs1() !== e) begin n_bad++; $display("FAIL sweep_digit1[%0d] got=%h exp=%h", i, obs1(), e); end
      n_cmp++;
      if (obs16() !== e) begin n_bad++; $display("FAIL sweep_digit16[%0d] got=%h exp=%h", i, obs16(), e); end
      sw_ready = 1'b1;
      @(posedge clk); #1;
      sw_ready = 1'b0;
    end
  endtask

  initial begin
    mif.in_valid = 1'b0;
    mif.out_ready = 1'b0;
    mif.a = '0;
    mif.b = '0;
    mif.cin = 1'b0;
    mif.op = '0;
    test_reset();
    test_arith();
    test_logic();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
